// File: rtl/toll_collector.sv
// toll_collector: coin-operated toll gate FSM; TOLL_TIMEOUT_EN adds a PAY inactivity timeout.
module toll_collector #(
    parameter int unsigned TOLL_H  = 12,
    parameter int unsigned TOLL_M  = 8,
    parameter int unsigned TOLL_L  = 4,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       E,
    input  logic       CAR,
    input  logic       COIN_VALID,
    input  logic [2:0] COIN_VAL,
    input  logic       PASS,
    output logic       GATE,
    output logic [5:0] CHANGE,
    output logic       VIOL,
    output logic       RATE_ERR,
    output logic       BUSY,
    output logic [7:0] CNT
);
    typedef enum logic [1:0] {S_IDLE, S_PAY, S_OPEN, S_VIOL} state_t;
    localparam logic [5:0] TH = TOLL_H[5:0];
    localparam logic [5:0] TM = TOLL_M[5:0];
    localparam logic [5:0] TL = TOLL_L[5:0];
    localparam logic [7:0] TO = TIMEOUT[7:0];
    state_t     state_q, state_d;
    logic [5:0] toll_q, toll_d, credit_q, credit_d, change_q, change_d;
    logic       gate_q, gate_d, viol_q, viol_d, rate_err_q, rate_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       one_hot, coin_ok, paid, timeout_hit;
    logic [5:0] toll_sel, credit_add;
    logic [6:0] sum;
    always_comb begin
        one_hot    = $onehot({H, M, L, E});
        toll_sel   = !one_hot ? TH : E ? 6'd0 : H ? TH : M ? TM : TL;
        coin_ok    = COIN_VALID && COIN_VAL != 3'd0;
        sum        = {1'b0, credit_q} + {4'd0, COIN_VAL};
        credit_add = sum[6] ? 6'd63 : sum[5:0];
        paid       = credit_add >= toll_q;
    end
`ifdef TOLL_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    // Timer restarts whenever PAY is entered or a coin lands; only idle PAY cycles count.
    always_comb timer_d = (state_q != S_PAY || coin_ok) ? 8'd0 : timer_q + 8'd1;
    always_ff @(posedge CLK) timer_q <= RST ? 8'd0 : timer_d;
    assign timeout_hit = state_q == S_PAY && !coin_ok && timer_d == TO;
`else
    logic unused_timeout;
    assign unused_timeout = ^TO;
    assign timeout_hit    = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            toll_q     <= 6'd0;
            credit_q   <= 6'd0;
            change_q   <= 6'd0;
            gate_q     <= 1'b0;
            viol_q     <= 1'b0;
            rate_err_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            toll_q     <= toll_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            gate_q     <= gate_d;
            viol_q     <= viol_d;
            rate_err_q <= rate_err_d;
            cnt_q      <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (CAR) state_d = toll_sel == 6'd0 ? S_OPEN : S_PAY;
            S_PAY:   if (PASS || timeout_hit) state_d = S_VIOL;
                     else if (coin_ok && paid) state_d = S_OPEN;
            S_OPEN:  if (PASS) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        toll_d     = toll_q;
        credit_d   = credit_q;
        change_d   = change_q;
        viol_d     = viol_q;
        rate_err_d = rate_err_q;
        cnt_d      = cnt_q;
        if (state_q == S_IDLE && CAR) begin
            toll_d     = toll_sel;
            credit_d   = 6'd0;
            change_d   = 6'd0;
            viol_d     = 1'b0;
            rate_err_d = !one_hot;
        end
        // A same-cycle PASS discards the coin: the vehicle already ran the gate.
        if (state_q == S_PAY && coin_ok && !PASS) begin
            credit_d = credit_add;
            change_d = paid ? credit_add - toll_q : 6'd0;
        end
        if (state_q == S_OPEN && PASS) begin
            change_d = 6'd0;
            cnt_d    = cnt_q + 8'd1;
        end
        if (state_d == S_VIOL) viol_d = 1'b1;
        gate_d = state_d == S_OPEN;
    end
    assign GATE     = gate_q;
    assign CHANGE   = change_q;
    assign VIOL     = viol_q;
    assign RATE_ERR = rate_err_q;
    assign BUSY     = state_q != S_IDLE;
    assign CNT      = cnt_q;
endmodule

// File: tb/tb_toll_collector.sv
// tb_toll_collector: scoreboard bench; every output change is matched against a queued snapshot and cycle.
module tb_toll_collector;
    typedef struct {
        string       name;
        int          cyc;
        logic [17:0] vec;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst, h, m, l, e, car, coin_valid, pass, probe, probe_d;
    logic [2:0] coin_val;
    logic       gate, viol, rate_err, busy;
    logic [5:0] change;
    logic [7:0] cnt, ec;
    logic [17:0] prev = 18'd0;
    logic [17:0] now;
    int         cycle = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       q[$];
    exp_t       ex;
    toll_collector dut (
        .CLK(clk), .RST(rst), .H(h), .M(m), .L(l), .E(e), .CAR(car),
        .COIN_VALID(coin_valid), .COIN_VAL(coin_val), .PASS(pass),
        .GATE(gate), .CHANGE(change), .VIOL(viol), .RATE_ERR(rate_err),
        .BUSY(busy), .CNT(cnt)
    );
    initial forever #5 clk = ~clk;
    always @(posedge clk) begin
        cycle   <= cycle + 1;
        probe_d <= probe;
    end
    always @(negedge clk) begin
        now = {gate, change, viol, rate_err, busy, cnt};
        if (now != prev || probe_d) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected: got %h at cycle %0d, required no change", now, cycle);
            end else begin
                ex = q.pop_front();
                if (now !== ex.vec || cycle != ex.cyc) begin
                    bad++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             ex.name, now, cycle, ex.vec, ex.cyc);
                end
            end
        end
        prev = now;
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_at(input string n, input int d, input logic g, input logic [5:0] ch,
                             input logic v, input logic re, input logic b, input logic [7:0] c);
        exp_t t;
        t.name = n;
        t.cyc  = cycle + d;
        t.vec  = {g, ch, v, re, b, c};
        q.push_back(t);
    endtask
    task automatic do_car(input logic hh, input logic mm, input logic ll, input logic ee);
        {h, m, l, e} = {hh, mm, ll, ee};
        car = 1'b1;
        cyc();
        {h, m, l, e, car} = 5'd0;
    endtask
    task automatic do_coin(input logic [2:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        cyc();
        coin_valid = 1'b0;
        coin_val   = 3'd0;
    endtask
    task automatic do_pass(input logic with_coin);
        pass       = 1'b1;
        coin_valid = with_coin;
        coin_val   = with_coin ? 3'd1 : 3'd0;
        cyc();
        pass       = 1'b0;
        coin_valid = 1'b0;
        coin_val   = 3'd0;
    endtask
    task automatic probe_chk(input string n, input logic g, input logic [5:0] ch, input logic v,
                             input logic re, input logic b, input logic [7:0] c);
        probe = 1'b1;
        expect_at(n, 1, g, ch, v, re, b, c);
        cyc();
        probe = 1'b0;
    endtask
    initial begin
        {h, m, l, e, car, coin_valid, pass} = 7'd0;
        coin_val = 3'd0;
        rst      = 1'b1;
        probe_chk("reset", 0, 0, 0, 0, 0, 8'd0);
        cyc();
        rst = 1'b0;
        expect_at("car_m", 1, 0, 0, 0, 0, 1, 8'd0); do_car(0, 1, 0, 0);
        do_coin(3'd5);
        expect_at("open_m", 1, 1, 6'd2, 0, 0, 1, 8'd0); do_coin(3'd5);
        do_coin(3'd5);
        do_car(1, 0, 0, 0);
        expect_at("pass_m", 1, 0, 0, 0, 0, 0, 8'd1); do_pass(0);
        expect_at("car_e", 1, 1, 0, 0, 0, 1, 8'd1); do_car(0, 0, 0, 1);
        expect_at("pass_e", 1, 0, 0, 0, 0, 0, 8'd2); do_pass(0);
        expect_at("car_hl", 1, 0, 0, 0, 1, 1, 8'd2); do_car(1, 0, 1, 0);
        do_coin(3'd7);
        expect_at("open_hl", 1, 1, 6'd2, 0, 1, 1, 8'd2); do_coin(3'd7);
        expect_at("pass_hl", 1, 0, 0, 0, 1, 0, 8'd3); do_pass(0);
        expect_at("car_none", 1, 0, 0, 0, 1, 1, 8'd3); do_car(0, 0, 0, 0);
        do_coin(3'd7);
        expect_at("open_none", 1, 1, 6'd0, 0, 1, 1, 8'd3); do_coin(3'd5);
        expect_at("pass_none", 1, 0, 0, 0, 1, 0, 8'd4); do_pass(0);
        expect_at("car_l", 1, 0, 0, 0, 0, 1, 8'd4); do_car(0, 0, 1, 0);
        do_coin(3'd3);
        expect_at("viol_l", 1, 0, 0, 1, 0, 1, 8'd4);
        expect_at("viol_l_idle", 2, 0, 0, 1, 0, 0, 8'd4); do_pass(0);
        cyc();
        do_coin(3'd7);
        expect_at("car_clr", 1, 0, 0, 0, 0, 1, 8'd4); do_car(0, 1, 0, 0);
        do_car(0, 0, 0, 1);
        do_coin(3'd0);
        do_coin(3'd7);
        expect_at("pass_wins", 1, 0, 0, 1, 0, 1, 8'd4);
        expect_at("pass_wins_idle", 2, 0, 0, 1, 0, 0, 8'd4); do_pass(1);
        cyc();
        expect_at("car_h", 1, 0, 0, 0, 0, 1, 8'd4); do_car(1, 0, 0, 0);
        ec = 8'd4;
`ifdef TOLL_TIMEOUT_EN
        expect_at("timeout", 201, 0, 0, 1, 0, 1, ec);
        expect_at("timeout_idle", 202, 0, 0, 1, 0, 0, ec); do_coin(3'd4);
        repeat (205) cyc();
`else
        do_coin(3'd4);
        repeat (1000) cyc();
        probe_chk("still_pay", 0, 0, 0, 0, 1, ec);
        do_coin(3'd7);
        expect_at("open_h", 1, 1, 6'd0, 0, 0, 1, ec); do_coin(3'd1);
        ec = ec + 8'd1;
        expect_at("pass_h", 1, 0, 0, 0, 0, 0, ec); do_pass(0);
`endif
        while (ec != 8'd255) begin
            expect_at("car_w", 1, 1, 0, 0, 0, 1, ec); do_car(0, 0, 0, 1);
            ec = ec + 8'd1;
            expect_at("pass_w", 1, 0, 0, 0, 0, 0, ec); do_pass(0);
        end
        expect_at("car_255", 1, 1, 0, 0, 0, 1, 8'd255); do_car(0, 0, 0, 1);
        expect_at("cnt_wrap", 1, 0, 0, 0, 0, 0, 8'd0); do_pass(0);
        expect_at("car_e2", 1, 1, 0, 0, 0, 1, 8'd0); do_car(0, 0, 0, 1);
        expect_at("pass_e2", 1, 0, 0, 0, 0, 0, 8'd1); do_pass(0);
        expect_at("car_m2", 1, 0, 0, 0, 0, 1, 8'd1); do_car(0, 1, 0, 0);
        do_coin(3'd7);
        expect_at("open_m2", 1, 1, 6'd6, 0, 0, 1, 8'd1); do_coin(3'd7);
        rst = 1'b1;
        probe_chk("rst_open", 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        expect_at("car_m3", 1, 0, 0, 0, 0, 1, 8'd0); do_car(0, 1, 0, 0);
        do_coin(3'd7);
        expect_at("open_m3", 1, 1, 6'd0, 0, 0, 1, 8'd0); do_coin(3'd1);
        expect_at("pass_m3", 1, 0, 0, 0, 0, 0, 8'd1); do_pass(0);
        repeat (5) cyc();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations pending, first %s, required 0", q.size(), q[0].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
